coherence_bus_ctrl: RTL and testbench

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

---
 rtl/coherence_bus_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// Two-CPU coherence bus controller: arbitrates dcache/icache traffic onto one RAM port,
// snoops the peer cache on data reads, and forwards dirty lines cache-to-cache.
module coherence_bus_ctrl #(
    parameter int CPUS = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [CPUS-1:0]           iREN,
    input  logic [CPUS-1:0][31:0]     iaddr,
    output logic [CPUS-1:0]           iwait,
    output logic [CPUS-1:0][31:0]     iload,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [CPUS-1:0][31:0]     daddr,
    input  logic [CPUS-1:0][31:0]     dstore,
    output logic [CPUS-1:0]           dwait,
    output logic [CPUS-1:0][31:0]     dload,
    input  logic [CPUS-1:0]           ccwrite,
    input  logic [CPUS-1:0]           cctrans,
    output logic [CPUS-1:0]           ccwait,
    output logic [CPUS-1:0]           ccinv,
    output logic [CPUS-1:0][31:0]     ccsnoopaddr,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  logic [1:0]                ramstate
);

    typedef enum logic [2:0] {IDLE, ARB, WB, SNOOP, RAMLD, C2C, INV, IFETCH} state_t;

    state_t r_state;
    logic   r_grant;
    logic   r_lastGrant;
    logic   r_invPhase;

    state_t w_arbNext;
    logic   w_arbGrant;
    logic   w_arbValid;
    logic   w_other;
    logic   w_ramReady;

    assign w_other    = ~r_grant;
    assign w_ramReady = (ramstate == 2'd2);

    // A tie goes to the CPU that was not granted last; a lone requester always wins.
    function automatic logic pickCpu(input logic [1:0] req, input logic last);
        if (req == 2'b11)
            return ~last;
        return req[1];
    endfunction

    always_comb begin
        w_arbValid = 1'b1;
        w_arbNext  = IDLE;
        w_arbGrant = 1'b0;
        if (|dWEN) begin
            w_arbNext  = WB;
            w_arbGrant = pickCpu(dWEN, r_lastGrant);
        end else if (|dREN) begin
            w_arbNext  = SNOOP;
            w_arbGrant = pickCpu(dREN, r_lastGrant);
        end else if (|ccwrite) begin
            w_arbNext  = INV;
            w_arbGrant = pickCpu(ccwrite, r_lastGrant);
        end else if (|iREN) begin
            w_arbNext  = IFETCH;
            w_arbGrant = pickCpu(iREN, r_lastGrant);
        end else begin
            w_arbValid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_invPhase  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|(dREN | dWEN | ccwrite | iREN))
                        r_state <= ARB;
                end
                ARB: begin
                    r_invPhase <= 1'b0;
                    if (w_arbValid) begin
                        r_state     <= w_arbNext;
                        r_grant     <= w_arbGrant;
                        r_lastGrant <= w_arbGrant;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WB: begin
                    if (!dWEN[r_grant])
                        r_state <= IDLE;
                end
                SNOOP:
                    r_state <= cctrans[w_other] ? C2C : RAMLD;
                RAMLD, C2C: begin
                    if (!dREN[r_grant])
                        r_state <= IDLE;
                end
                INV: begin
                    if (r_invPhase)
                        r_state <= IDLE;
                    r_invPhase <= 1'b1;
                end
                IFETCH: begin
                    if (w_ramReady)
                        r_state <= IDLE;
                end
                default:
                    r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; only the ready handshake follows ramstate directly.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (r_state)
            WB: begin
                ramWEN           = 1'b1;
                ramaddr          = daddr[r_grant];
                ramstore         = dstore[r_grant];
                dwait[r_grant]   = ~w_ramReady;
            end
            SNOOP: begin
                ccwait[w_other]      = 1'b1;
                ccsnoopaddr[w_other] = daddr[r_grant];
                ccinv[w_other]       = ccwrite[r_grant];
            end
            RAMLD: begin
                ramREN           = 1'b1;
                ramaddr          = daddr[r_grant];
                dload[r_grant]   = ramload;
                dwait[r_grant]   = ~w_ramReady;
            end
            C2C: begin
                ccwait[w_other]      = 1'b1;
                ccsnoopaddr[w_other] = daddr[r_grant];
                dload[r_grant]       = dstore[w_other];
                ramWEN               = 1'b1;
                ramaddr              = daddr[r_grant];
                ramstore             = dstore[w_other];
                dwait[r_grant]       = ~w_ramReady;
            end
            INV: begin
                if (!r_invPhase) begin
                    ccwait[w_other]      = 1'b1;
                    ccinv[w_other]       = 1'b1;
                    ccsnoopaddr[w_other] = daddr[r_grant];
                end else begin
                    ccinv[r_grant] = 1'b1;
                    dwait[r_grant] = 1'b0;
                end
            end
            IFETCH: begin
                ramREN           = 1'b1;
                ramaddr          = iaddr[r_grant];
                iload[r_grant]   = ramload;
                iwait[r_grant]   = ~w_ramReady;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: a vector table of single transactions plus hand sequences
// for arbitration order and mid-transaction reset; completions are matched against a queue.
module tb_coherence_bus_ctrl;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_INV, OP_IF} op_e;

    typedef struct {
        op_e         op;
        logic        cpu;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ccw;
        logic        peerDirty;
        logic [31:0] peerData;
        logic [31:0] expLoad;
        int          expSnoop;
        logic        expInv;
        logic        expRamWen;
        logic [31:0] expStore;
    } vec_t;

    typedef struct {
        logic        cpu;
        logic [31:0] data;
        logic        chkData;
    } sb_t;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic [1:0]       ccwrite;
    logic [1:0]       cctrans;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;
    logic [1:0]       ramCnt;

    int  nErrors;
    int  nChecks;
    sb_t sbQ[$];

    coherence_bus_ctrl #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] memVal(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_DEAD : (a ^ 32'hA5A5_0000);
    endfunction

    // RAM answers ACCESS on the third consecutive enabled cycle, BUSY before that.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)
            ramCnt <= 2'd0;
        else if (!(ramREN || ramWEN) || ramCnt == 2'd2)
            ramCnt <= 2'd0;
        else
            ramCnt <= ramCnt + 2'd1;
    end
    assign ramstate = (ramREN || ramWEN) ? ((ramCnt == 2'd2) ? 2'd2 : 2'd1) : 2'd0;
    assign ramload  = memVal(ramaddr);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        ccwrite = '0; cctrans = '0;
    endtask

    task automatic applyReset();
        clearInputs();
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic pushExp(input logic cpu, input logic [31:0] data, input logic chk);
        sb_t e;
        e.cpu = cpu; e.data = data; e.chkData = chk;
        sbQ.push_back(e);
    endtask

    // Drives one cache transaction, watches it to completion and checks what was seen.
    task automatic applyStimulus(input vec_t v, input bit doPush);
        logic c, o, done, invSeen, bothEn, iwaitBad;
        logic compWen, compRen, compSelfInv, compSelfWait, expRen;
        logic [31:0] snoopAddr, load, compStore;
        int snoopCyc, invCyc, doneCyc;
        sb_t e;
        c = v.cpu; o = ~v.cpu;
        done = 0; invSeen = 0; bothEn = 0; iwaitBad = 0;
        compWen = 0; compRen = 0; compSelfInv = 0; compSelfWait = 0;
        snoopAddr = '0; load = '0; compStore = '0;
        snoopCyc = 0; invCyc = 0; doneCyc = 0;
        expRen = (v.op == OP_IF) || (v.op == OP_RD && !v.peerDirty);
        @(posedge CLK); #1;
        case (v.op)
            OP_RD: begin
                daddr[c] = v.addr; ccwrite[c] = v.ccw;
                cctrans[o] = v.peerDirty; dstore[o] = v.peerData; dREN[c] = 1'b1;
            end
            OP_WR:  begin daddr[c] = v.addr; dstore[c] = v.wdata; dWEN[c] = 1'b1; end
            OP_INV: begin daddr[c] = v.addr; ccwrite[c] = 1'b1; end
            default: begin iaddr[c] = v.addr; iREN[c] = 1'b1; end
        endcase
        if (doPush)
            pushExp(c, v.expLoad, (v.op == OP_RD) || (v.op == OP_IF));
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge CLK);
            if (ramREN && ramWEN) bothEn = 1;
            if (v.op == OP_IF && ramWEN && !iwait[c]) iwaitBad = 1;
            if (ccwait[o] && !ramWEN && !ramREN) begin
                snoopCyc++;
                snoopAddr = ccsnoopaddr[o];
            end
            if (ccinv[o]) begin invSeen = 1; invCyc = cyc; end
            if ((v.op == OP_IF) ? !iwait[c] : !dwait[c]) begin
                done = 1; doneCyc = cyc;
                load = (v.op == OP_IF) ? iload[c] : dload[c];
                compWen = ramWEN; compRen = ramREN; compStore = ramstore;
                compSelfInv = ccinv[c]; compSelfWait = ccwait[c];
                if (sbQ.size() == 0) begin
                    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd1);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("orderCpu", 32'(c), 32'(e.cpu));
                    if (e.chkData) checkOutput("loadData", load, e.data);
                end
            end
        end
        @(posedge CLK); #1;
        if (v.op == OP_RD) begin dREN[c] = 1'b0; ccwrite[c] = 1'b0; cctrans[o] = 1'b0; end
        if (v.op == OP_WR) dWEN[c] = 1'b0;
        if (v.op == OP_INV) ccwrite[c] = 1'b0;
        if (v.op == OP_IF) iREN[c] = 1'b0;
        checkOutput("completed", 32'(done), 32'd1);
        if (done) begin
            checkOutput("snoopCycles", 32'(snoopCyc), 32'(v.expSnoop));
            if (v.expSnoop != 0) checkOutput("snoopAddr", snoopAddr, v.addr);
            checkOutput("ccinvOther", 32'(invSeen), 32'(v.expInv));
            checkOutput("ramWenAtDone", 32'(compWen), 32'(v.expRamWen));
            if (v.expRamWen) checkOutput("ramStore", compStore, v.expStore);
            checkOutput("ramRenAtDone", 32'(compRen), 32'(expRen));
            checkOutput("selfInv", 32'(compSelfInv), 32'(v.op == OP_INV));
            checkOutput("selfWait", 32'(compSelfWait), 32'd0);
            checkOutput("bothEnables", 32'(bothEn), 32'd0);
            if (v.op == OP_IF) checkOutput("iwaitDuringWb", 32'(iwaitBad), 32'd0);
            if (v.op == OP_INV) checkOutput("invToDone", 32'(doneCyc - invCyc), 32'd1);
        end
    endtask

    vec_t vecs[10];
    vec_t va, vb;
    int   bad;

    initial begin
        nErrors = 0;
        nChecks = 0;
        clearInputs();
        nRST = 1'b0;
        #1;
        checkOutput("rstDwait", 32'(dwait), 32'h3);
        checkOutput("rstIwait", 32'(iwait), 32'h3);
        checkOutput("rstCcwait", 32'(ccwait), 32'h0);
        checkOutput("rstCcinv", 32'(ccinv), 32'h0);
        checkOutput("rstRamEn", 32'({ramREN, ramWEN}), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        vecs[0] = '{OP_RD,  1'b0, 32'h100,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0000DEAD, 1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{OP_RD,  1'b0, 32'h140,  32'h0,        1'b1, 1'b1, 32'h0000BEEF, 32'h0000BEEF, 1, 1'b1, 1'b1, 32'h0000BEEF};
        vecs[2] = '{OP_WR,  1'b1, 32'h300,  32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h12345678};
        vecs[3] = '{OP_INV, 1'b1, 32'h200,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{OP_IF,  1'b0, 32'h40,   32'h0,        1'b0, 1'b0, 32'h0,        32'hA5A50040, 0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{OP_IF,  1'b1, 32'h1000, 32'h0,        1'b0, 1'b0, 32'h0,        32'hA5A51000, 0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{OP_RD,  1'b1, 32'h180,  32'h0,        1'b0, 1'b0, 32'h0,        32'hA5A50180, 1, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{OP_RD,  1'b1, 32'h1C0,  32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[8] = '{OP_WR,  1'b0, 32'h340,  32'h0BADF00D, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0BADF00D};
        vecs[9] = '{OP_RD,  1'b1, 32'h240,  32'h0,        1'b1, 1'b0, 32'h0,        32'hA5A50240, 1, 1'b1, 1'b0, 32'h0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], 1'b1);
            repeat (2) @(posedge CLK);
        end

        // Simultaneous reads straight out of reset: CPU0 first, then CPU1.
        applyReset();
        va = '{OP_RD, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0, 32'hA5A50400, 1, 1'b0, 1'b0, 32'h0};
        vb = '{OP_RD, 1'b1, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 32'hA5A50500, 1, 1'b0, 1'b0, 32'h0};
        pushExp(1'b0, 32'hA5A50400, 1'b1);
        pushExp(1'b1, 32'hA5A50500, 1'b1);
        fork
            applyStimulus(va, 1'b0);
            applyStimulus(vb, 1'b0);
        join
        repeat (2) @(posedge CLK);

        // After CPU0 wins alone, the next tie must go to CPU1.
        va = '{OP_RD, 1'b0, 32'h440, 32'h0, 1'b0, 1'b0, 32'h0, 32'hA5A50440, 1, 1'b0, 1'b0, 32'h0};
        applyStimulus(va, 1'b1);
        repeat (2) @(posedge CLK);
        va = '{OP_RD, 1'b0, 32'h480, 32'h0, 1'b0, 1'b0, 32'h0, 32'hA5A50480, 1, 1'b0, 1'b0, 32'h0};
        vb = '{OP_RD, 1'b1, 32'h540, 32'h0, 1'b0, 1'b0, 32'h0, 32'hA5A50540, 1, 1'b0, 1'b0, 32'h0};
        pushExp(1'b1, 32'hA5A50540, 1'b1);
        pushExp(1'b0, 32'hA5A50480, 1'b1);
        fork
            applyStimulus(va, 1'b0);
            applyStimulus(vb, 1'b0);
        join
        repeat (2) @(posedge CLK);

        // A dcache writeback beats a simultaneous instruction fetch.
        va = '{OP_IF, 1'b0, 32'h80,  32'h0,        1'b0, 1'b0, 32'h0, 32'hA5A50080, 0, 1'b0, 1'b0, 32'h0};
        vb = '{OP_WR, 1'b1, 32'h600, 32'h000055AA, 1'b0, 1'b0, 32'h0, 32'h0,        0, 1'b0, 1'b1, 32'h000055AA};
        pushExp(1'b1, 32'h0, 1'b0);
        pushExp(1'b0, 32'hA5A50080, 1'b1);
        fork
            applyStimulus(va, 1'b0);
            applyStimulus(vb, 1'b0);
        join
        repeat (2) @(posedge CLK);

        // Reset in the middle of a RAM load abandons it without a completion pulse.
        @(posedge CLK); #1;
        daddr[0] = 32'h700;
        dREN[0]  = 1'b1;
        for (int k = 0; k < 20 && !ramREN; k++) @(negedge CLK);
        checkOutput("reachRamld", 32'(ramREN), 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("midRstDwait", 32'(dwait), 32'h3);
        checkOutput("midRstIwait", 32'(iwait), 32'h3);
        checkOutput("midRstRamEn", 32'({ramREN, ramWEN}), 32'h0);
        checkOutput("midRstCc", 32'({ccwait, ccinv}), 32'h0);
        dREN[0] = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (!dwait[0] || ramREN || ramWEN) bad++;
        end
        checkOutput("postRstQuiet", 32'(bad), 32'd0);

        va = '{OP_RD, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0000DEAD, 1, 1'b0, 1'b0, 32'h0};
        applyStimulus(va, 1'b1);

        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
